// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared scoreboard constants, entry record and select decode
package reg_scoreboard_pkg;

    localparam int SB_DEPTH = 4;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;
    localparam int OCC_W    = 3;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [SEL_W-1:0] wr_sel;
    } sb_entry_t;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_REGS'(1) << sel;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - in-order entry storage with wrapping pointers, pop and partial flush
module sb_fifo
    import reg_scoreboard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  sb_entry_t        i_push_entry,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [OCC_W-1:0] i_flush_keep,
    output sb_entry_t        o_slots [DEPTH],
    output sb_entry_t        o_head,
    output logic [OCC_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sb_entry_t        r_slots [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] w_keep;
    logic [OCC_W-1:0] w_remain;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W-1:0] w_wr_flush;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [OCC_W-1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    function automatic int slot_off(input int idx, input logic [PTR_W-1:0] base);
        int d;
        d = idx - int'(base);
        if (d < 0) d = d + DEPTH;
        return d;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_slots[r_rd_ptr];
    assign o_slots = r_slots;

    // The kept count is measured before the pop; the write pointer lands just
    // past whatever survives so the pointers stay consistent with the count.
    always_comb begin
        w_push     = i_push & ~o_full;
        w_pop      = i_pop & ~o_empty;
        w_keep     = (i_flush_keep < r_count) ? i_flush_keep : r_count;
        w_rd_next  = w_pop ? ptr_add(r_rd_ptr, OCC_W'(1)) : r_rd_ptr;
        w_remain   = (w_pop && (w_keep != '0)) ? w_keep - OCC_W'(1) : w_keep;
        w_wr_flush = ptr_add(w_rd_next, w_remain);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((slot_off(i, r_rd_ptr) >= int'(w_keep)) ||
                    (w_pop && (PTR_W'(i) == r_rd_ptr)))
                    r_slots[i].valid <= 1'b0;
            end
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= w_wr_flush;
            r_count  <= w_remain;
        end else begin
            if (w_push) begin
                r_slots[r_wr_ptr] <= i_push_entry;
                r_wr_ptr          <= ptr_add(r_wr_ptr, OCC_W'(1));
            end
            if (w_pop) r_slots[r_rd_ptr].valid <= 1'b0;
            r_rd_ptr <= w_rd_next;
            r_count  <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register hazard scoreboard: pending mask, issue stall, sticky error
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issueValid,
    input  logic                issueWrEn,
    input  logic [SEL_W-1:0]    issueWrSel,
    input  logic [SEL_W-1:0]    issueRd1Sel,
    input  logic [SEL_W-1:0]    issueRd2Sel,
    input  logic                issueRd1Used,
    input  logic                issueRd2Used,
    input  logic                retireValid,
    input  logic [SEL_W-1:0]    retireWrSel,
    input  logic                flush,
    input  logic [OCC_W-1:0]    flushKeep,
    output logic                stall,
    output logic [NUM_REGS-1:0] pendingMask,
    output logic [OCC_W-1:0]    occupancy,
    output logic                err
);

    sb_entry_t           w_slots [DEPTH];
    sb_entry_t           w_head;
    sb_entry_t           w_push_entry;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_err_set;
    logic [NUM_REGS-1:0] w_pending;
    logic                r_err;

    assign w_push_entry = '{valid: 1'b1, wr_en: issueWrEn, wr_sel: issueWrSel};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (retireValid),
        .i_flush      (flush),
        .i_flush_keep (flushKeep),
        .o_slots      (w_slots),
        .o_head       (w_head),
        .o_count      (occupancy),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slots[i].valid && w_slots[i].wr_en)
                w_pending = w_pending | sel_onehot(w_slots[i].wr_sel);
        end
    end

    // No retire bypass: a source retiring this cycle is still pending here.
    assign pendingMask = w_pending;
    assign stall  = issueValid & (w_full |
                                  (issueRd1Used & w_pending[issueRd1Sel]) |
                                  (issueRd2Used & w_pending[issueRd2Sel]));
    assign w_push = issueValid & ~stall & ~flush;

    assign w_err_set = (retireValid & w_empty) |
                       (retireValid & w_head.valid & w_head.wr_en & (retireWrSel != w_head.wr_sel)) |
                       (retireValid & w_head.wr_en & $isunknown(retireWrSel)) |
                       (issueValid & issueWrEn & $isunknown(issueWrSel)) |
                       (issueValid & issueRd1Used & $isunknown(issueRd1Sel)) |
                       (issueValid & issueRd2Used & $isunknown(issueRd2Sel));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err | w_err_set;
    end

    assign err = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issueValid, issueWrEn, issueRd1Used, issueRd2Used;
    logic [2:0] issueWrSel, issueRd1Sel, issueRd2Sel;
    logic       retireValid, flush;
    logic [2:0] retireWrSel, flushKeep;
    logic       stall, err;
    logic [7:0] pendingMask;
    logic [2:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] regs_b [4] = '{3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] regs_c [3] = '{3'd1, 3'd2, 3'd4};
    logic [2:0] regs_f [3] = '{3'd1, 3'd2, 3'd3};

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issueValid   (issueValid),
        .issueWrEn    (issueWrEn),
        .issueWrSel   (issueWrSel),
        .issueRd1Sel  (issueRd1Sel),
        .issueRd2Sel  (issueRd2Sel),
        .issueRd1Used (issueRd1Used),
        .issueRd2Used (issueRd2Used),
        .retireValid  (retireValid),
        .retireWrSel  (retireWrSel),
        .flush        (flush),
        .flushKeep    (flushKeep),
        .stall        (stall),
        .pendingMask  (pendingMask),
        .occupancy    (occupancy),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issueValid   = 1'b0;
        issueWrEn    = 1'b0;
        issueWrSel   = 3'd0;
        issueRd1Sel  = 3'd0;
        issueRd2Sel  = 3'd0;
        issueRd1Used = 1'b0;
        issueRd2Used = 1'b0;
        retireValid  = 1'b0;
        retireWrSel  = 3'd0;
        flush        = 1'b0;
        flushKeep    = 3'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [2:0] r);
        idle();
        issueValid = 1'b1;
        issueWrEn  = 1'b1;
        issueWrSel = r;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #12;
        chk("reset_stall", stall, 8'h0);
        chk("reset_pmask", pendingMask, 8'h00);
        chk("reset_occ", occupancy, 8'h0);
        chk("reset_err", err, 8'h0);
        rst = 1'b1;
        cyc();

        // RAW hazard on R3, retire in the stalled cycle, clear next cycle
        issue_wr(3'd3);
        #1 chk("a_issue_nostall", stall, 8'h0);
        cyc();
        issueWrEn    = 1'b0;
        issueRd1Sel  = 3'd3;
        issueRd1Used = 1'b1;
        retireValid  = 1'b1;
        retireWrSel  = 3'd3;
        #1;
        chk("a_raw_stall", stall, 8'h1);
        chk("a_pmask", pendingMask, 8'h08);
        chk("a_occ", occupancy, 8'h1);
        cyc();
        retireValid = 1'b0;
        #1;
        chk("a_after_retire_stall", stall, 8'h0);
        chk("a_after_retire_pmask", pendingMask, 8'h00);
        chk("a_after_retire_occ", occupancy, 8'h0);
        idle();

        // fill to DEPTH, fifth issue stalls on full
        for (int i = 0; i < 4; i++) begin
            issue_wr(regs_b[i]);
            #1 chk("b_fill_nostall", stall, 8'h0);
            cyc();
        end
        idle();
        #1;
        chk("b_full_occ", occupancy, 8'h4);
        chk("b_full_pmask", pendingMask, 8'h36);
        issue_wr(3'd6);
        #1 chk("b_full_stall", stall, 8'h1);
        cyc();
        idle();
        #1;
        chk("b_no_push_occ", occupancy, 8'h4);
        chk("b_no_push_pmask", pendingMask, 8'h36);
        for (int i = 0; i < 4; i++) begin
            retireValid = 1'b1;
            retireWrSel = regs_b[i];
            cyc();
        end
        idle();
        #1;
        chk("b_drain_occ", occupancy, 8'h0);
        chk("b_drain_pmask", pendingMask, 8'h00);
        chk("b_drain_err", err, 8'h0);

        // flush keeping one, with a suppressed same-cycle issue
        for (int i = 0; i < 3; i++) begin
            issue_wr(regs_c[i]);
            cyc();
        end
        idle();
        #1;
        chk("c_occ3", occupancy, 8'h3);
        chk("c_pmask3", pendingMask, 8'h16);
        issue_wr(3'd7);
        flush     = 1'b1;
        flushKeep = 3'd1;
        cyc();
        idle();
        #1;
        chk("c_keep1_occ", occupancy, 8'h1);
        chk("c_keep1_pmask", pendingMask, 8'h02);

        // flush keep=3 with same-cycle retire leaves two
        issue_wr(3'd2);
        cyc();
        issue_wr(3'd4);
        cyc();
        idle();
        flush       = 1'b1;
        flushKeep   = 3'd3;
        retireValid = 1'b1;
        retireWrSel = 3'd1;
        cyc();
        idle();
        #1;
        chk("c_keep3_retire_occ", occupancy, 8'h2);
        chk("c_keep3_retire_pmask", pendingMask, 8'h14);
        chk("c_keep3_retire_err", err, 8'h0);
        flush     = 1'b1;
        flushKeep = 3'd0;
        cyc();
        idle();
        #1;
        chk("c_keep0_occ", occupancy, 8'h0);
        chk("c_keep0_pmask", pendingMask, 8'h00);
        issue_wr(3'd3);
        cyc();
        idle();
        flush     = 1'b1;
        flushKeep = 3'd5;
        cyc();
        idle();
        #1;
        chk("c_keep_over_occ", occupancy, 8'h1);
        chk("c_keep_over_pmask", pendingMask, 8'h08);
        retireValid = 1'b1;
        retireWrSel = 3'd3;
        cyc();
        idle();
        #1 chk("c_retire_occ", occupancy, 8'h0);

        // same-cycle retire of R6 and read of R6 via Rd2
        issue_wr(3'd6);
        cyc();
        idle();
        retireValid  = 1'b1;
        retireWrSel  = 3'd6;
        issueValid   = 1'b1;
        issueRd2Used = 1'b1;
        issueRd2Sel  = 3'd6;
        #1 chk("d_no_bypass_stall", stall, 8'h1);
        cyc();
        retireValid = 1'b0;
        #1;
        chk("d_next_stall", stall, 8'h0);
        chk("d_next_pmask", pendingMask, 8'h00);
        chk("d_next_occ", occupancy, 8'h0);
        idle();

        // retire on empty sets sticky err
        chk("e_err_before", err, 8'h0);
        retireValid = 1'b1;
        retireWrSel = 3'd0;
        cyc();
        idle();
        #1;
        chk("e_err_set", err, 8'h1);
        chk("e_occ", occupancy, 8'h0);
        cyc();
        chk("e_err_sticky", err, 8'h1);

        // asynchronous reset mid-cycle with three entries pending
        for (int i = 0; i < 3; i++) begin
            issue_wr(regs_f[i]);
            cyc();
        end
        idle();
        #1;
        chk("f_occ3", occupancy, 8'h3);
        chk("f_pmask", pendingMask, 8'h0E);
        issueValid   = 1'b1;
        issueRd1Used = 1'b1;
        issueRd1Sel  = 3'd1;
        #1 chk("f_stall_before", stall, 8'h1);
        #2 rst = 1'b0;
        #1;
        chk("f_async_pmask", pendingMask, 8'h00);
        chk("f_async_occ", occupancy, 8'h0);
        chk("f_async_stall", stall, 8'h0);
        chk("f_async_err", err, 8'h0);
        #3 rst = 1'b1;
        idle();
        cyc();

        // retire select disagreeing with head destination
        issue_wr(3'd2);
        cyc();
        idle();
        retireValid = 1'b1;
        retireWrSel = 3'd5;
        cyc();
        idle();
        #1;
        chk("g_mismatch_err", err, 8'h1);
        chk("g_mismatch_occ", occupancy, 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of in-flight register-writing instructions tracked.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port issueValid, input, 1, meaning decode presents an instruction this cycle.
REQ-005 SHALL have port issueWrEn, input, 1, meaning the issuing instruction writes a register.
REQ-006 SHALL have port issueWrSel, input, 3, the destination register of the issuing instruction.
REQ-007 SHALL have ports issueRd1Sel and issueRd2Sel, input, 3 each, the source registers of the issuing instruction.
REQ-008 SHALL have ports issueRd1Used and issueRd2Used, input, 1 each, meaning the corresponding source is actually read.
REQ-009 SHALL have port retireValid, input, 1, meaning writeback commits the oldest tracked entry this cycle.
REQ-010 SHALL have port retireWrSel, input, 3, the register being written to the register file at retire.
REQ-011 SHALL have port flush, input, 1, meaning squash younger in-flight instructions.
REQ-012 SHALL have port flushKeep, input, 3, the number of oldest entries that survive a flush.
REQ-013 SHALL have port stall, output, 1, meaning decode must hold the issuing instruction.
REQ-014 SHALL have port pendingMask, output, 8, where bit n is set while register n has an unretired writer.
REQ-015 SHALL have port occupancy, output, 3, the number of valid tracked entries.
REQ-016 SHALL have port err, output, 1, the sticky protocol-error flag.

Function
REQ-017 SHALL hold entries in an in-order FIFO of DEPTH slots, each slot holding {valid, wrEn, wrSel}.
REQ-018 SHALL drive stall combinationally as issueValid & (full | (issueRd1Used & pendingMask[issueRd1Sel]) | (issueRd2Used & pendingMask[issueRd2Sel])).
REQ-019 SHALL push one entry {1, issueWrEn, issueWrSel} on a rising edge when issueValid & ~stall & ~flush.
REQ-020 SHALL NOT bypass retire: a source that matches an entry retiring in the same cycle still stalls for that cycle.
REQ-021 SHALL pop the head entry on a rising edge when retireValid is high and the FIFO is non-empty.
REQ-022 SHALL compute pendingMask as the OR over valid entries with wrEn=1 of the one-hot decode of wrSel.
REQ-023 SHALL, on flush, keep the min(flushKeep, occupancy) oldest entries (counted before any same-cycle pop), invalidate the rest, and suppress any push that cycle.
REQ-024 SHALL, on flush with a same-cycle retire, first pop the head and then apply the kept count, leaving min(flushKeep, occupancy) - 1 entries when that count is nonzero.
REQ-025 SHALL wrap read and write pointers modulo DEPTH, with full defined as occupancy == DEPTH and empty as occupancy == 0.
REQ-026 SHALL set err, and hold it until reset, when retireValid arrives while empty, when retireWrSel differs from the head wrSel of a wrEn=1 head, or when any select input is X/Z while used.
REQ-027 SHALL treat a protocol-error retire on an empty FIFO as a no-op on state.
REQ-028 SHALL register occupancy, so that the output updates one cycle after the push, pop, or flush edge.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear all valid bits and both pointers, set occupancy=0 and err=0, and thereby give pendingMask=0 and stall=0.
REQ-030 SHALL discard all in-flight tracking on reset asserted mid-operation, with no retire required afterward.

Structure
REQ-031 SHALL take DEPTH and a scoreboard-entry record type from the shared processor package, alongside the register-count constant (8) and the select width (3).
REQ-032 SHALL contain one sub-module, sb_fifo, holding the entry storage and pointers; pendingMask/stall logic SHALL stay in the top module.

Verification
REQ-033 SHALL be verified by this scenario: issue a write to R3, then the next cycle issue an instruction reading R3 with Rd1Used=1 -> stall=1 and pendingMask=8'h08; after retire R3, the following cycle has stall=0.
REQ-034 SHALL be verified by this scenario: issue 4 writes (R1,R2,R4,R5) with no retire -> occupancy=4; a fifth issueValid with no source hazard gives stall=1 and no push.
REQ-035 SHALL be verified by this scenario: FIFO holds R1,R2,R4, flush with flushKeep=1 -> next cycle occupancy=1 and pendingMask=8'h02.
REQ-036 SHALL be verified by this scenario: FIFO holds R6, same-cycle retire R6 and issue reading R6 -> stall=1 that cycle, stall=0 the next cycle, pendingMask=0.
REQ-037 SHALL be verified by this scenario: retireValid on an empty FIFO -> err=1, occupancy stays 0, and err holds until rst=0.
REQ-038 SHALL be verified by this scenario: rst pulsed low with 3 entries pending -> pendingMask=0, occupancy=0, and stall=0 immediately, with no clock edge needed.
